// File: rtl/kmp_fail_func_gen_if.sv
// Request/result bundle between a pattern source and the KMP failure-function generator.
interface kmp_fail_func_gen_if #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 32,
  parameter int IDX_W   = 5
);
  // Level handshake: the source raises i_valid with stable request fields and holds it
  // until it has consumed o_valid; dropping i_valid early aborts, dropping it after
  // o_valid returns the generator to idle. The table stays readable until the next load.
  logic                       i_valid;
  logic [MAX_LEN*SYM_W-1:0]   i_pattern;
  logic [IDX_W-1:0]           i_last_idx;
  logic                       i_nocase;
  logic [MAX_LEN*IDX_W-1:0]   o_fail_func;
  logic                       o_valid;
  logic                       o_busy;
  logic                       o_err;

  modport master (
    output i_valid, i_pattern, i_last_idx, i_nocase,
    input  o_fail_func, o_valid, o_busy, o_err
  );

  modport slave (
    input  i_valid, i_pattern, i_last_idx, i_nocase,
    output o_fail_func, o_valid, o_busy, o_err
  );
endinterface

// File: rtl/kmp_fail_func_gen.sv
// KMP prefix-function table generator: one compare or one back-track step per cycle,
// with optional ASCII case folding applied to the latched pattern.
module kmp_fail_func_gen #(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 32,
  parameter int IDX_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  kmp_fail_func_gen_if.slave  bus,
  output logic [3:0]          dbg_state
);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_LOAD = 4'b0010;
  localparam logic [3:0] S_CALC = 4'b0100;
  localparam logic [3:0] S_DONE = 4'b1000;

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [31:0]      MAX_LEN_U = 32'(MAX_LEN);

  logic [3:0]               state;
  logic                     armed;
  logic [MAX_LEN*SYM_W-1:0] pat_q;
  logic [MAX_LEN*SYM_W-1:0] cap_pat;
  logic [IDX_W-1:0]         last_q;
  logic [IDX_W-1:0]         q;
  logic [IDX_W-1:0]         k;
  logic                     err_q;
  logic                     cap_err;
  logic [MAX_LEN*IDX_W-1:0] f_q;
  logic [SYM_W-1:0]         sym_k;
  logic [SYM_W-1:0]         sym_q;
  logic [IDX_W-1:0]         f_back;

  // Folding only makes sense for byte-wide ASCII symbols; other widths pass through.
  if (SYM_W == 8) begin : g_fold
    always_comb begin
      cap_pat = bus.i_pattern;
      if (bus.i_nocase) begin
        for (int j = 0; j < MAX_LEN; j++) begin
          if (bus.i_pattern[j*8 +: 8] >= 8'h61 && bus.i_pattern[j*8 +: 8] <= 8'h7a)
            cap_pat[j*8 +: 8] = bus.i_pattern[j*8 +: 8] - 8'h20;
        end
      end
    end
  end else begin : g_nofold
    logic unused_nocase;
    assign unused_nocase = bus.i_nocase;
    assign cap_pat       = bus.i_pattern;
  end

  assign cap_err = 32'(bus.i_last_idx) >= MAX_LEN_U;
  assign sym_k   = pat_q[k*SYM_W +: SYM_W];
  assign sym_q   = pat_q[q*SYM_W +: SYM_W];
  // Only consulted while k>0, so the k-1 index never underflows when it matters.
  assign f_back  = f_q[(k - IDX_ONE)*IDX_W +: IDX_W];

  assign bus.o_fail_func = f_q;
  assign bus.o_valid     = (state == S_DONE);
  assign bus.o_busy      = (state == S_LOAD) || (state == S_CALC);
  assign bus.o_err       = err_q && (state == S_DONE);
  assign dbg_state       = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      armed  <= 1'b0;
      pat_q  <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
      f_q    <= '0;
      q      <= '0;
      k      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // The request is latched on the accepting edge; LOAD starts one cycle later.
          if (armed) begin
            armed <= 1'b0;
            if (bus.i_valid) state <= S_LOAD;
          end else if (bus.i_valid) begin
            pat_q  <= cap_pat;
            last_q <= bus.i_last_idx;
            err_q  <= cap_err;
            armed  <= 1'b1;
          end
        end
        S_LOAD: begin
          f_q <= '0;
          q   <= IDX_ONE;
          k   <= '0;
          if (!bus.i_valid)  state <= S_IDLE;
          else if (err_q)    state <= S_DONE;
          else               state <= S_CALC;
        end
        S_CALC: begin
          if (!bus.i_valid) begin
            state <= S_IDLE;
          end else if (last_q == '0) begin
            state <= S_DONE;
          end else if (sym_k == sym_q) begin
            f_q[q*IDX_W +: IDX_W] <= k + IDX_ONE;
            k <= k + IDX_ONE;
            q <= q + IDX_ONE;
            if (q == last_q) state <= S_DONE;
          end else if (k != '0) begin
            k <= f_back;
          end else begin
            f_q[q*IDX_W +: IDX_W] <= '0;
            q <= q + IDX_ONE;
            if (q == last_q) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.i_valid) begin
            state <= S_IDLE;
            err_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmp_fail_func_gen.sv
// Bench for kmp_fail_func_gen: directed and random patterns against a brute-force
// prefix-function model, with cycle-exact completion latency.
module tb_kmp_fail_func_gen;

  localparam int SW = 8;
  localparam int ML = 16;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic [3:0] dbg_a;
  logic [3:0] dbg_b;

  kmp_fail_func_gen_if #(.SYM_W(SW), .MAX_LEN(ML), .IDX_W(IW)) bus_a ();
  kmp_fail_func_gen_if #(.SYM_W(7),  .MAX_LEN(4),  .IDX_W(2))  bus_b ();

  kmp_fail_func_gen #(.SYM_W(SW), .MAX_LEN(ML), .IDX_W(IW)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a), .dbg_state(dbg_a)
  );
  kmp_fail_func_gen #(.SYM_W(7), .MAX_LEN(4), .IDX_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b), .dbg_state(dbg_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] tp [ML];
  logic [ML*IW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tp(input string s);
    for (int j = 0; j < ML; j++) tp[j] = (j < s.len()) ? s[j] : 8'h00;
  endtask

  // Table by definition (longest proper border of each prefix); cycle count from the
  // textbook while-loop, where every inner iteration costs one extra cycle.
  task automatic model_a(input int last, input bit nocase,
                         output logic [ML*IW-1:0] tbl, output int n);
    int p [ML];
    int f [ML];
    int k;
    int b;
    for (int i = 0; i < ML; i++) begin
      p[i] = int'(tp[i]);
      if (nocase && p[i] >= 97 && p[i] <= 122) p[i] -= 32;
      f[i] = 0;
    end
    tbl = '0;
    for (int qq = 1; qq <= last; qq++) begin
      int best = 0;
      for (int len = 1; len <= qq; len++) begin
        bit ok = 1'b1;
        for (int j = 0; j < len; j++) if (p[j] != p[qq-len+1+j]) ok = 1'b0;
        if (ok && len < qq + 1) best = len;
      end
      if (best == qq + 1) best = qq;
      f[qq] = best;
      tbl[qq*IW +: IW] = IW'(best);
    end
    if (last == 0) begin
      n = 1;
    end else begin
      k = 0;
      b = 0;
      for (int qq = 1; qq <= last; qq++) begin
        while (k > 0 && p[k] != p[qq]) begin
          k = f[k-1];
          b++;
        end
        if (p[k] == p[qq]) k++;
      end
      n = last + b;
    end
  endtask

  task automatic run_a(input string tag, input int last, input bit nocase,
                       input int chg_at, output int lat);
    logic [ML*IW-1:0] etbl;
    int n;
    int exp_lat;
    int busy_cnt;
    bit err;
    err = (last >= ML);
    if (err) begin
      etbl = '0;
      exp_lat = 2;
    end else begin
      model_a(last, nocase, etbl, n);
      exp_lat = 2 + n;
    end
    exp_q.push_back(etbl);
    for (int j = 0; j < ML; j++) bus_a.i_pattern[j*SW +: SW] = tp[j];
    bus_a.i_last_idx = IW'(last);
    bus_a.i_nocase   = nocase;
    bus_a.i_valid    = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    busy_cnt = 0;
    for (int m = 1; m <= 200 && lat < 0; m++) begin
      @(posedge clk); #1;
      if (m == chg_at)
        for (int j = 0; j < ML; j++) bus_a.i_pattern[j*SW +: SW] = 8'($urandom);
      if (bus_a.o_busy === 1'b1) busy_cnt++;
      if (bus_a.o_valid === 1'b1) lat = m;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " busy_cycles"}, 128'(busy_cnt), 128'(exp_lat - 1));
    check({tag, " table"}, 128'(bus_a.o_fail_func), 128'(exp_q.pop_front()));
    check({tag, " err"}, 128'(bus_a.o_err), 128'(err));
    bus_a.i_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, " release"}, 128'({bus_a.o_valid, bus_a.o_err, bus_a.o_busy}), 128'(0));
  endtask

  task automatic run_b(input string tag, input logic [27:0] pat, input logic [1:0] last,
                       input bit nocase, input logic [7:0] exp_tbl);
    int lat;
    bus_b.i_pattern  = pat;
    bus_b.i_last_idx = last;
    bus_b.i_nocase   = nocase;
    bus_b.i_valid    = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int m = 1; m <= 50 && lat < 0; m++) begin
      @(posedge clk); #1;
      if (bus_b.o_valid === 1'b1) lat = m;
    end
    check({tag, " latency"}, 128'(lat), 128'(3));
    check({tag, " table"}, 128'(bus_b.o_fail_func), 128'(exp_tbl));
    bus_b.i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    string alph;
    alph = "AABBab";
    bus_a.i_valid = 1'b0; bus_a.i_pattern = '0; bus_a.i_last_idx = '0; bus_a.i_nocase = 1'b0;
    bus_b.i_valid = 1'b0; bus_b.i_pattern = '0; bus_b.i_last_idx = '0; bus_b.i_nocase = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset flags", 128'({bus_a.o_valid, bus_a.o_busy, bus_a.o_err}), 128'(0));
    check("reset table", 128'(bus_a.o_fail_func), 128'(0));
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;

    set_tp("ABAB");
    run_a("abab", 3, 1'b0, 0, lat);
    check("abab lat5", 128'(lat), 128'(5));
    check("abab table 0,0,1,2", 128'(bus_a.o_fail_func), 128'(80'h10400));

    set_tp("AABAAA");
    run_a("aabaaa", 5, 1'b0, 0, lat);
    check("aabaaa lat9", 128'(lat), 128'(9));
    check("aabaaa table 0,1,0,1,2,2", 128'(bus_a.o_fail_func), 128'(80'h4208020));

    set_tp("aA");
    run_a("aA nocase", 1, 1'b1, 0, lat);
    check("aA nocase table 0,1", 128'(bus_a.o_fail_func), 128'(80'h20));
    run_a("aA case", 1, 1'b0, 0, lat);
    check("aA case table 0,0", 128'(bus_a.o_fail_func), 128'(0));

    set_tp("AB");
    run_a("last0", 0, 1'b0, 0, lat);
    check("last0 lat3", 128'(lat), 128'(3));

    set_tp("AAAAAAAAAAAAAAAA");
    run_a("fullA", ML - 1, 1'b0, 0, lat);
    check("fullA lat", 128'(lat), 128'(2 + ML - 1));

    run_a("err16", ML, 1'b0, 0, lat);
    run_a("err31", 31, 1'b0, 0, lat);

    // Abort during the second CALC cycle.
    set_tp("ABAB");
    for (int j = 0; j < ML; j++) bus_a.i_pattern[j*SW +: SW] = tp[j];
    bus_a.i_last_idx = IW'(3);
    bus_a.i_nocase = 1'b0;
    bus_a.i_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus_a.i_valid = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 128'(bus_a.o_busy), 128'(0));
    begin
      int seen = 0;
      for (int m = 0; m < 10; m++) begin
        @(posedge clk); #1;
        if (bus_a.o_valid !== 1'b0) seen++;
      end
      check("abort no valid", 128'(seen), 128'(0));
    end
    set_tp("AAAA");
    run_a("aaaa", 3, 1'b0, 0, lat);
    check("aaaa table 0,1,2,3", 128'(bus_a.o_fail_func), 128'(80'h18820));

    // Reset mid-CALC.
    for (int j = 0; j < ML; j++) bus_a.i_pattern[j*SW +: SW] = tp[j];
    bus_a.i_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("rst calc flags", 128'({bus_a.o_valid, bus_a.o_busy, bus_a.o_err}), 128'(0));
    check("rst calc table", 128'(bus_a.o_fail_func), 128'(0));
    rst_a = 1'b0;
    bus_a.i_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while DONE holds a non-zero table.
    bus_a.i_valid = 1'b1;
    lat = -1;
    for (int m = 0; m <= 50 && lat < 0; m++) begin
      @(posedge clk); #1;
      if (bus_a.o_valid === 1'b1) lat = m;
    end
    check("pre-rst done table", 128'(bus_a.o_fail_func), 128'(80'h18820));
    rst_a = 1'b1;
    bus_a.i_valid = 1'b0;
    @(posedge clk); #1;
    check("rst done flags", 128'({bus_a.o_valid, bus_a.o_busy, bus_a.o_err}), 128'(0));
    check("rst done table", 128'(bus_a.o_fail_func), 128'(0));
    rst_a = 1'b0;
    @(posedge clk); #1;

    set_tp("ABABAB");
    run_a("chg during calc", 5, 1'b0, 3, lat);

    for (int it = 0; it < 25; it++) begin
      int last_r;
      bit nc;
      last_r = $urandom_range(0, ML - 1);
      nc = 1'($urandom_range(0, 1));
      for (int j = 0; j < ML; j++) tp[j] = alph[$urandom_range(0, 5)];
      run_a($sformatf("rand%0d", it), last_r, nc, ($urandom_range(0, 1) == 1) ? 3 : 0, lat);
    end

    // 7-bit symbols: folding must not apply.
    run_b("sym7 aA nocase", {7'h00, 7'h00, 7'h41, 7'h61}, 2'd1, 1'b1, 8'h00);
    run_b("sym7 AA nocase", {7'h00, 7'h00, 7'h41, 7'h41}, 2'd1, 1'b1, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
